// File: rtl/sobel_recebe_imagem.sv
// Frame loader: writes UART bytes in raster order into the input frame memory,
// with a one-byte holding register and a mid-frame inter-byte timeout resync.
module sobel_recebe_imagem #(
    parameter int LARGURA = 64,
    parameter int ALTURA  = 64,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_enable,
    input  logic [7:0]        uart_dado,
    input  logic              uart_pronto,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dado,
    output logic              rx_pronto,
    output logic              fim_imagem,
    output logic              db_erro,
    output logic [3:0]        db_estado
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] ULTIMO  = ADDR_W'(LARGURA * ALTURA - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] OCIOSO   = 3'd0;
    localparam logic [2:0] ESPERA   = 3'd1;
    localparam logic [2:0] GRAVA    = 3'd2;
    localparam logic [2:0] COMPLETO = 3'd3;
    localparam logic [2:0] ERRO     = 3'd4;

    logic [2:0]        r_estado;
    logic [ADDR_W-1:0] r_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_pend;
    logic [7:0]        r_pend_byte;
    logic [7:0]        r_byte;
    logic              r_erro;
    logic              w_grava;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_pend      <= 1'b0;
            r_pend_byte <= 8'h00;
            r_byte      <= 8'h00;
            r_erro      <= 1'b0;
        end else if (!rx_enable) begin
            // Dropping enable wins over byte arrival and timeout in every state
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_pend   <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_cnt    <= '0;
                    r_tmo    <= '0;
                    r_pend   <= 1'b0;
                    r_erro   <= 1'b0;
                    r_estado <= ESPERA;
                end
                ESPERA: begin
                    if (uart_pronto || r_pend) begin
                        // Held byte goes first; a simultaneous new byte takes its place
                        r_byte <= r_pend ? r_pend_byte : uart_dado;
                        r_pend <= r_pend && uart_pronto;
                        if (r_pend && uart_pronto)
                            r_pend_byte <= uart_dado;
                        r_estado <= GRAVA;
                    end else if (r_cnt != '0) begin
                        if (r_tmo == TMO_MAX) begin
                            r_estado <= ERRO;
                            r_erro   <= 1'b1;
                            r_cnt    <= '0;
                            r_tmo    <= '0;
                            r_pend   <= 1'b0;
                        end else if (r_tmo != '1) begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                GRAVA: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_tmo <= '0;
                    if (uart_pronto) begin
                        r_pend      <= 1'b1;
                        r_pend_byte <= uart_dado;
                    end
                    r_estado <= (r_cnt == ULTIMO) ? COMPLETO : ESPERA;
                end
                COMPLETO: begin
                    r_estado <= COMPLETO;
                end
                ERRO: begin
                    r_estado <= ESPERA;
                end
                default: begin
                    r_estado <= OCIOSO;
                    r_cnt    <= '0;
                    r_tmo    <= '0;
                    r_pend   <= 1'b0;
                    r_erro   <= 1'b0;
                end
            endcase
        end
    end

    assign w_grava    = (r_estado == GRAVA);
    assign mem_we     = w_grava;
    assign mem_addr   = r_cnt;
    assign mem_dado   = w_grava ? r_byte : 8'h00;
    assign rx_pronto  = (r_estado == COMPLETO);
    assign fim_imagem = (r_estado == COMPLETO);
    assign db_erro    = r_erro;

    always_comb begin
        db_estado = 4'hE;
        case (r_estado)
            OCIOSO:   db_estado = 4'h0;
            ESPERA:   db_estado = 4'h1;
            GRAVA:    db_estado = 4'h2;
            COMPLETO: db_estado = 4'h3;
            ERRO:     db_estado = 4'h4;
            default:  db_estado = 4'hE;
        endcase
    end

endmodule
